// File: rtl/uart_tx_if.sv
// uart_tx host-side bundle: byte write strobe in, serial line and status out.
interface uart_tx_if;
  logic       write;
  logic [7:0] data;
  logic       tx;
  logic       txrdy;
  logic       txbusy;

  modport master (
    output write, data,
    input  tx, txrdy, txbusy
  );

  modport slave (
    input  write, data,
    output tx, txrdy, txbusy
  );
endinterface

// File: rtl/uart_tx.sv
// 16x-oversampled UART transmitter: 8 data bits, parity, one stop bit,
// single-entry holding register so frames can run back-to-back.
module uart_tx #(
  parameter int unsigned PARITY_MODE = 1
) (
  input  logic      mclkx16,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic [7:0] thr, thr_n;
  logic       par, par_n;
  logic       write2;
  logic       rdy, rdy_n;
  logic       busy, busy_n;
  logic       txq, tx_n;
  logic       rise;
  logic       tc;
  logic       xfer;

  assign rise = bus.write && !write2;
  assign tc   = (cnt == 4'd15);
  // THR is full exactly when txrdy is low
  assign xfer = !rdy &&
    (state == IDLE || (state == STOP && tc));

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 4'd1;
    idx_n   = idx;
    sh_n    = sh;
    thr_n   = thr;
    par_n   = par;
    rdy_n   = rdy;
    busy_n  = busy;
    tx_n    = 1'b1;

    if (rise && rdy) begin
      thr_n = bus.data;
      rdy_n = 1'b0;
    end

    unique case (state)
      IDLE: cnt_n = 4'd0;
      START: if (tc) state_n = DATA;
      DATA: begin
        if (tc) begin
          sh_n  = sh >> 1;
          idx_n = idx + 3'd1;
          if (idx == 3'd7) state_n = PARITY;
        end
      end
      PARITY: if (tc) state_n = STOP;
      STOP: begin
        if (tc) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (xfer) begin
      sh_n    = thr;
      par_n   = (PARITY_MODE != 0) ? ~^thr : ^thr;
      rdy_n   = 1'b1;
      busy_n  = 1'b1;
      cnt_n   = 4'd0;
      idx_n   = 3'd0;
      state_n = START;
    end

    // line level follows the state being entered
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = sh_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge mclkx16 or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      idx    <= 3'd0;
      sh     <= 8'd0;
      thr    <= 8'd0;
      par    <= 1'b0;
      write2 <= 1'b1;
      rdy    <= 1'b1;
      busy   <= 1'b0;
      txq    <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      idx    <= idx_n;
      sh     <= sh_n;
      thr    <= thr_n;
      par    <= par_n;
      write2 <= bus.write;
      rdy    <= rdy_n;
      busy   <= busy_n;
      txq    <= tx_n;
    end
  end

  assign bus.tx     = txq;
  assign bus.txrdy  = rdy;
  assign bus.txbusy = busy;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: odd and even parity instances share one stimulus and
// are compared every cycle against a frame-level timeline model.
module tb_uart_tx;

  localparam int MAXC = 4096;

  logic       mclkx16 = 1'b0;
  logic       reset = 1'b1;
  logic       write = 1'b0;
  logic [7:0] data = 8'd0;

  uart_tx_if b0();
  uart_tx_if b1();

  assign b0.write = write;
  assign b0.data  = data;
  assign b1.write = write;
  assign b1.data  = data;

  uart_tx #(.PARITY_MODE(1)) u_odd (
    .mclkx16(mclkx16),
    .reset(reset),
    .bus(b0.slave)
  );

  uart_tx #(.PARITY_MODE(0)) u_even (
    .mclkx16(mclkx16),
    .reset(reset),
    .bus(b1.slave)
  );

  always #5 mclkx16 = ~mclkx16;

  int n_run = 0;
  int n_fail = 0;
  int scn = 0;

  int         s_n[32];
  int         s_len[32];
  logic [7:0] s_d[32];
  int         s_cnt;

  bit e_tx0[MAXC];
  bit e_tx1[MAXC];
  bit e_rdy[MAXC];
  bit e_busy[MAXC];

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int ones(logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(d[i]);
    return n;
  endfunction

  // Expected line/status after each clock edge, from frame rules only
  task automatic build(int len);
    int acc_n = -100;
    int t_p = -100;
    int last_end = -1000;
    for (int c = 0; c < len; c++) begin
      e_tx0[c] = 1'b1;
      e_tx1[c] = 1'b1;
      e_rdy[c] = 1'b1;
      e_busy[c] = 1'b0;
    end
    for (int i = 0; i < s_cnt; i++) begin
      int n = s_n[i];
      int t;
      bit odd_p;
      if ((n - 1) >= acc_n && (n - 1) < t_p) continue;
      t = (last_end > n + 1) ? last_end : n + 1;
      odd_p = (ones(s_d[i]) % 2) == 0;
      for (int c = n; c < t && c < len; c++) e_rdy[c] = 1'b0;
      for (int c = t; c < t + 176 && c < len; c++) begin
        int k = (c - t) / 16;
        bit b;
        if (k == 0) b = 1'b0;
        else if (k <= 8) b = s_d[i][k-1];
        else if (k == 9) b = odd_p;
        else b = 1'b1;
        e_tx0[c] = b;
        e_tx1[c] = (k == 9) ? !odd_p : b;
        e_busy[c] = 1'b1;
      end
      acc_n = n;
      t_p = t;
      last_end = t + 176;
    end
  endtask

  task automatic run(int len);
    scn++;
    reset = 1'b1;
    write = 1'b0;
    repeat (2) @(negedge mclkx16);
    reset = 1'b0;
    build(len);
    for (int r = 0; r < len; r++) begin
      bit act = 1'b0;
      logic [7:0] dv = 8'd0;
      if (r > 0) @(negedge mclkx16);
      chk($sformatf("s%0d_r%0d", scn, r),
          {2'b00, b0.tx, b1.tx, b0.txrdy, b0.txbusy,
           b1.txrdy, b1.txbusy},
          {2'b00, e_tx0[r], e_tx1[r], e_rdy[r], e_busy[r],
           e_rdy[r], e_busy[r]});
      for (int i = 0; i < s_cnt; i++)
        if (s_n[i] <= r + 1 && r + 1 < s_n[i] + s_len[i]) begin
          act = 1'b1;
          dv = s_d[i];
        end
      write = act;
      data = act ? dv : 8'($urandom);
    end
  endtask

  task automatic add(int n, int len, logic [7:0] d);
    s_n[s_cnt] = n;
    s_len[s_cnt] = len;
    s_d[s_cnt] = d;
    s_cnt++;
  endtask

  initial begin
    s_cnt = 0;
    run(60);

    s_cnt = 0;
    add(3, 1, 8'h55);
    add(200, 2, 8'h01);
    add(400, 1, 8'h00);
    add(600, 3, 8'hFF);
    add(800, 1, 8'h5A);
    run(1000);

    s_cnt = 0;
    add(3, 1, 8'hA3);
    add(23, 2, 8'h3C);
    add(60, 2, 8'h77);
    add(180, 1, 8'hEE);
    run(400);

    for (int it = 0; it < 3; it++) begin
      int t = 2 + $urandom_range(0, 20);
      s_cnt = 0;
      while (t < 1800 && s_cnt < 32) begin
        int l = $urandom_range(1, 3);
        add(t, l, 8'($urandom));
        t += l + 1 + $urandom_range(0, 260);
      end
      run(2000);
    end

    // reset in the middle of d4 with write held high across release
    s_cnt = 0;
    add(3, 1, 8'h55);
    run(92);
    @(negedge mclkx16);
    write = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_async", {5'd0, b0.tx, b0.txrdy, b0.txbusy}, 8'h06);
    chk("rst_async_e", {5'd0, b1.tx, b1.txrdy, b1.txbusy}, 8'h06);
    repeat (3) @(negedge mclkx16);
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge mclkx16);
      chk($sformatf("rst_hold%0d", i),
          {2'b00, b0.tx, b1.tx, b0.txrdy, b1.txrdy,
           b0.txbusy, b1.txbusy}, 8'h3C);
    end
    write = 1'b0;
    @(negedge mclkx16);
    write = 1'b1;
    data = 8'h81;
    @(negedge mclkx16);
    chk("rearm_n", {6'd0, b0.txrdy, b0.tx}, 8'h01);
    write = 1'b0;
    @(negedge mclkx16);
    chk("rearm_start", {5'd0, b0.tx, b0.txbusy, b0.txrdy}, 8'h03);
    repeat (24) @(negedge mclkx16);
    chk("rearm_d0", {7'd0, b0.tx}, 8'h01);
    repeat (128) @(negedge mclkx16);
    chk("rearm_par", {6'd0, b0.tx, b1.tx}, 8'h02);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
